bp_stream_to_lite: RTL and testbench

BP_STREAM_TO_LITE -- requirements
Module: bp_stream_to_lite

---
 rtl/bp_stream_to_lite.sv | 221 ++++++++++++++++++++++
 tb/tb_bp_stream_to_lite.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_stream_to_lite.sv
// rtl/bp_stream_to_lite.sv - collects narrow mem-stream beats into one wide lite message
//
// Purpose
//   Gathers the beats of one stream message into a wide register. The header
//   is taken from beat 0 and the message is presented as a single lite
//   message: header in the upper bits, data in the lower bits.
//
// Ports
//   clk_i            in   1                   clock, all state on the rising edge
//   reset_i          in   1                   asynchronous, active-high reset
//   mem_header_i     in   HDR                 stream header, valid with every beat
//   mem_data_i       in   in_data_width_p     stream beat data
//   mem_v_i          in   1                   beat valid
//   mem_ready_and_o  out  1                   beat taken when mem_v_i & mem_ready_and_o
//   mem_o            out  HDR+out_data_width  lite message {header, data}
//   mem_v_o          out  1                   lite message valid
//   mem_yumi_i       in   1                   consumer takes mem_o (only while mem_v_o)
//
// Header layout (LSB first): msg_type[3:0], addr[paddr-1:0], size[2:0],
// payload {lce_id, way}. Size encodes a byte count of (1 << size).

package bp_stream_to_lite_pkg;

  typedef enum int {
    e_bp_default_cfg = 0
  } bp_params_e;

  typedef enum logic [3:0] {
    e_mem_msg_rd    = 4'd0,
    e_mem_msg_wr    = 4'd1,
    e_mem_msg_uc_rd = 4'd2,
    e_mem_msg_uc_wr = 4'd3,
    e_mem_msg_pre   = 4'd4,
    e_mem_msg_amo   = 4'd5
  } bp_mem_msg_e;

  localparam int mem_msg_width_gp  = 4;
  localparam int mem_size_width_gp = 3;

  function automatic int cfg_paddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 40;
      default:          return 40;
    endcase
  endfunction

  function automatic int cfg_lce_id_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 4;
      default:          return 4;
    endcase
  endfunction

  function automatic int cfg_lce_assoc(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 8;
      default:          return 8;
    endcase
  endfunction

  function automatic int cfg_mem_header_width(bp_params_e cfg);
    return mem_msg_width_gp + cfg_paddr_width(cfg) + mem_size_width_gp
         + cfg_lce_id_width(cfg) + $clog2(cfg_lce_assoc(cfg));
  endfunction

endpackage

module bp_stream_to_lite
  import bp_stream_to_lite_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_default_cfg
    , parameter int in_data_width_p  = int'("inv")
    , parameter int out_data_width_p = int'("inv")
    , parameter int master_p         = 0
    // "inv" marks an unset width; fall back to a legal pair so the block
    // still elaborates on its own.
    , localparam int in_width_lp  = (in_data_width_p  == int'("inv")) ? 64  : in_data_width_p
    , localparam int out_width_lp = (out_data_width_p == int'("inv")) ? 512 : out_data_width_p
    , localparam int hdr_width_lp = cfg_mem_header_width(bp_params_p)
    )
  (input  logic                           clk_i
   , input  logic                         reset_i
   , input  logic [hdr_width_lp-1:0]      mem_header_i
   , input  logic [in_width_lp-1:0]       mem_data_i
   , input  logic                         mem_v_i
   , output logic                         mem_ready_and_o
   , output logic [hdr_width_lp+out_width_lp-1:0] mem_o
   , output logic                         mem_v_o
   , input  logic                         mem_yumi_i
   );

  localparam int paddr_width_lp = cfg_paddr_width(bp_params_p);
  localparam int ib_raw_lp      = in_width_lp / 8;
  localparam int ib_lp          = (ib_raw_lp > 0) ? ib_raw_lp : 1;
  localparam int w_raw_lp       = out_width_lp / in_width_lp;
  localparam int w_lp           = (w_raw_lp > 0) ? w_raw_lp : 1;
  localparam int cnt_width_lp   = (w_lp > 1) ? $clog2(w_lp) : 1;
  localparam int size_lsb_lp    = mem_msg_width_gp + paddr_width_lp;

  // Width sanity checks, reported while the design is elaborated.
  if (in_width_lp > out_width_lp) begin : g_err_narrow
    $error("bp_stream_to_lite: in_data_width_p exceeds out_data_width_p");
  end
  if ((out_width_lp % in_width_lp) != 0) begin : g_err_ratio
    $error("bp_stream_to_lite: out_data_width_p is not a multiple of in_data_width_p");
  end

  typedef enum logic {
    e_collect = 1'b0,
    e_full    = 1'b1
  } state_e;

  state_e                    state_r, state_n;
  logic [cnt_width_lp-1:0]   cnt_r;
  logic [cnt_width_lp-1:0]   last_r;     // index of the final beat, from beat 0
  logic [cnt_width_lp-1:0]   last_n;     // final-beat index decoded from the live header
  logic [hdr_width_lp-1:0]   hdr_r;
  logic [out_width_lp-1:0]   data_r;

  logic                      accept;
  logic                      first_beat;
  logic                      last_beat;
  logic [mem_msg_width_gp-1:0] msg_type;
  logic [mem_size_width_gp-1:0] msg_size;
  logic                      is_wr;
  int                        bytes_l;
  int                        beats_l;

  assign accept     = mem_v_i & mem_ready_and_o;
  assign first_beat = (cnt_r == '0);
  assign msg_type   = mem_header_i[mem_msg_width_gp-1:0];
  assign msg_size   = mem_header_i[size_lsb_lp +: mem_size_width_gp];
  assign is_wr      = (msg_type == e_mem_msg_wr) || (msg_type == e_mem_msg_uc_wr);

  // Beat count of the message starting on this beat. Data travels with
  // writes on the command side and with reads on the response side; every
  // other combination is a header-only, single-beat message.
  always_comb begin
    bytes_l = 1 << msg_size;
    beats_l = bytes_l / ib_lp;
    if (beats_l < 1) begin
      beats_l = 1;
    end
    if (beats_l > w_lp) begin
      beats_l = w_lp;
    end
    if (((master_p != 0) ^ is_wr) == 1'b0) begin
      beats_l = 1;
    end
    last_n = cnt_width_lp'(beats_l - 1);
  end

  // On beat 0 the beat count comes straight from the header being accepted;
  // later beats compare against the value latched from beat 0.
  assign last_beat = first_beat ? (last_n == '0) : (cnt_r == last_r);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_collect;
    end else begin
      state_r <= state_n;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_collect: if (accept && last_beat) state_n = e_full;
      e_full:    if (mem_yumi_i)          state_n = e_collect;
      default:   state_n = e_collect;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Ready is also gated by reset so that nothing is taken while reset is
  // held, even though the state register already reads COLLECT.
  always_comb begin
    mem_ready_and_o = 1'b0;
    mem_v_o         = 1'b0;
    case (state_r)
      e_collect: mem_ready_and_o = ~reset_i;
      e_full:    mem_v_o         = 1'b1;
      default:   ;
    endcase
  end

  // Beat counter: wraps to 0 on the final beat so the next message
  // starts from slot 0; reset discards any partially collected message.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_r <= '0;
    end else if (accept) begin
      cnt_r <= last_beat ? '0 : cnt_r + 1'b1;
    end
  end

  // Header and data capture. Beat 0 is written into every slot, which
  // yields the replicated image for single-beat messages; later beats then
  // overwrite their own slot. Later headers are ignored so the message
  // carries the address of beat 0.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      if (first_beat) begin
        hdr_r  <= mem_header_i;
        last_r <= last_n;
        data_r <= {w_lp{mem_data_i}};
      end else begin
        data_r[cnt_r*in_width_lp +: in_width_lp] <= mem_data_i;
      end
    end
  end

  assign mem_o = {hdr_r, data_r};

  // Every beat of one message must carry the same message type.
  assert property (@(posedge clk_i) disable iff (reset_i)
                   (accept && !first_beat) |-> (msg_type == hdr_r[mem_msg_width_gp-1:0]))
    else $error("bp_stream_to_lite: msg_type changed within a message");

endmodule

// File: tb/tb_bp_stream_to_lite.sv
// tb/tb_bp_stream_to_lite.sv - scoreboard bench for bp_stream_to_lite (64b beats, 512b messages)

module tb_bp_stream_to_lite;

  localparam int HDR = 54;
  localparam int MW  = HDR + 512;

  localparam logic [3:0] T_RD    = 4'd0;
  localparam logic [3:0] T_WR    = 4'd1;
  localparam logic [3:0] T_UC_WR = 4'd3;

  logic           clk = 1'b0;
  logic           rst;
  logic [HDR-1:0] hdr_in, m_hdr_in;
  logic [63:0]    data_in, m_data_in;
  logic           v_in, m_v_in;
  logic           ready, m_ready;
  logic [MW-1:0]  msg, m_msg;
  logic           v_o, m_v_o;
  logic           yumi, m_yumi;

  int n_checks = 0;
  int n_passed = 0;
  int n_failed = 0;

  logic [MW-1:0] exp_q[$];
  logic [MW-1:0] exp_m_q[$];

  always #5 clk = ~clk;

  bp_stream_to_lite #(.in_data_width_p(64), .out_data_width_p(512), .master_p(0)) dut (
    .clk_i(clk), .reset_i(rst), .mem_header_i(hdr_in), .mem_data_i(data_in),
    .mem_v_i(v_in), .mem_ready_and_o(ready), .mem_o(msg), .mem_v_o(v_o),
    .mem_yumi_i(yumi));

  bp_stream_to_lite #(.in_data_width_p(64), .out_data_width_p(512), .master_p(1)) dut_m (
    .clk_i(clk), .reset_i(rst), .mem_header_i(m_hdr_in), .mem_data_i(m_data_in),
    .mem_v_i(m_v_in), .mem_ready_and_o(m_ready), .mem_o(m_msg), .mem_v_o(m_v_o),
    .mem_yumi_i(m_yumi));

  function automatic logic [HDR-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] sz,
                                            input logic [39:0] a);
    return {7'h2b, sz, a, t};
  endfunction

  task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_passed++;
    end else begin
      n_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one beat and wait (bounded) until it is accepted.
  task automatic send(input bit m, input logic [HDR-1:0] h, input logic [63:0] d,
                      output int waited);
    logic acc;
    logic vo_seen;
    if (m) begin m_hdr_in = h; m_data_in = d; m_v_in = 1'b1; end
    else   begin hdr_in = h;   data_in = d;   v_in = 1'b1;   end
    waited  = 0;
    acc     = 1'b0;
    vo_seen = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc     = m ? m_ready : ready;
      vo_seen = m ? m_v_o : v_o;
      @(posedge clk);
      #1;
      waited++;
    end
    check(m ? "m beat accepted" : "beat accepted", MW'(acc), MW'(1));
    check(m ? "m v_o low while collecting" : "v_o low while collecting", MW'(vo_seen), MW'(0));
  endtask

  // Push the expected message, then stream its beats; later beats carry
  // shifted addresses that must not reach the captured header.
  task automatic send_msg(input bit m, input logic [3:0] t, input logic [2:0] sz,
                          input logic [39:0] a, input int n, input logic [63:0] base);
    logic [511:0] d;
    int w;
    if (n == 1) d = {8{base}};
    else begin
      d = '0;
      for (int k = 0; k < 8; k++) d[k*64 +: 64] = base + 64'(k);
    end
    if (m) exp_m_q.push_back({mk_hdr(t, sz, a), d});
    else   exp_q.push_back({mk_hdr(t, sz, a), d});
    for (int k = 0; k < n; k++) begin
      send(m, mk_hdr(t, sz, a + 40'(8 * k)), base + 64'(k), w);
    end
    if (m) m_v_in = 1'b0; else v_in = 1'b0;
  endtask

  // Scoreboard: compare whenever a message is taken.
  always @(negedge clk) begin
    if (!rst && v_o && yumi) begin
      if (exp_q.size() == 0) check("unexpected message", MW'(exp_q.size()), MW'(1));
      else check("message", msg, exp_q.pop_front());
    end
    if (!rst && m_v_o && m_yumi) begin
      if (exp_m_q.size() == 0) check("m unexpected message", MW'(exp_m_q.size()), MW'(1));
      else check("m message", m_msg, exp_m_q.pop_front());
    end
  end

  initial begin
    int w;
    rst = 1'b1;
    hdr_in = '0; data_in = '0; v_in = 1'b0; yumi = 1'b0;
    m_hdr_in = '0; m_data_in = '0; m_v_in = 1'b0; m_yumi = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready in reset", MW'(ready), MW'(0));
    check("v_o in reset", MW'(v_o), MW'(0));
    check("m ready in reset", MW'(m_ready), MW'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready after reset", MW'(ready), MW'(1));
    check("m ready after reset", MW'(m_ready), MW'(1));
    @(posedge clk); #1;
    yumi = 1'b1;
    m_yumi = 1'b1;

    // 8-beat write, immediate yumi
    send_msg(0, T_WR, 3'd6, 40'h1000, 8, 64'h0);
    @(negedge clk);
    check("wr v_o after last beat", MW'(v_o), MW'(1));
    check("wr ready low", MW'(ready), MW'(0));
    @(negedge clk);
    check("wr v_o dropped", MW'(v_o), MW'(0));
    check("wr ready back", MW'(ready), MW'(1));
    @(posedge clk); #1;

    // single-beat read, replicated
    send_msg(0, T_RD, 3'd6, 40'h2000, 1, 64'hAB);
    @(negedge clk);
    check("rd v_o after one beat", MW'(v_o), MW'(1));
    @(posedge clk); #1;

    // 4-byte uncached write, replicated
    send_msg(0, T_UC_WR, 3'd2, 40'h3004, 1, 64'h11223344);
    @(negedge clk);
    check("uc_wr v_o after one beat", MW'(v_o), MW'(1));
    @(posedge clk); #1;

    // backpressure: yumi withheld 5 cycles with the next beat pending
    yumi = 1'b0;
    send_msg(0, T_WR, 3'd6, 40'h4000, 8, 64'h100);
    exp_q.push_back({mk_hdr(T_WR, 3'd6, 40'h5000), {64'h207, 64'h206, 64'h205, 64'h204,
                     64'h203, 64'h202, 64'h201, 64'h200}});
    hdr_in = mk_hdr(T_WR, 3'd6, 40'h5000); data_in = 64'h200; v_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("held v_o", MW'(v_o), MW'(1));
      check("held ready", MW'(ready), MW'(0));
      check("held mem_o", msg, exp_q[0]);
      @(posedge clk); #1;
    end
    yumi = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send(0, mk_hdr(T_WR, 3'd6, 40'h5000 + 40'(8 * k)), 64'h200 + 64'(k), w);
      if (k == 0) check("accept cycle after yumi", MW'(w), MW'(2));
    end
    v_in = 1'b0;
    @(negedge clk);
    check("second msg v_o", MW'(v_o), MW'(1));
    @(posedge clk); #1;

    // reset in the middle of a message
    for (int k = 0; k < 4; k++) begin
      send(0, mk_hdr(T_WR, 3'd6, 40'h6000 + 40'(8 * k)), 64'h300 + 64'(k), w);
    end
    v_in = 1'b0;
    @(negedge clk);
    check("partial v_o", MW'(v_o), MW'(0));
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("mid reset ready", MW'(ready), MW'(0));
    check("mid reset v_o", MW'(v_o), MW'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post reset ready", MW'(ready), MW'(1));
    check("post reset v_o", MW'(v_o), MW'(0));
    @(posedge clk); #1;
    send_msg(0, T_WR, 3'd6, 40'h7000, 8, 64'h400);
    @(negedge clk);
    check("fresh msg v_o", MW'(v_o), MW'(1));
    @(posedge clk); #1;

    // response side: writes single beat, reads multi-beat
    send_msg(1, T_WR, 3'd6, 40'h8000, 1, 64'hCAFE);
    @(negedge clk);
    check("m wr v_o after one beat", MW'(m_v_o), MW'(1));
    @(posedge clk); #1;
    send_msg(1, T_RD, 3'd6, 40'h9000, 8, 64'h500);
    @(negedge clk);
    check("m rd v_o after eight beats", MW'(m_v_o), MW'(1));
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    check("scoreboard drained", MW'(exp_q.size()), MW'(0));
    check("m scoreboard drained", MW'(exp_m_q.size()), MW'(0));
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
